count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_mon_pkg.sv | 28 ++
 rtl/count_mon_sat_ctr.sv | 41 ++++
 rtl/count_monitor.sv | 150 +++++++++++++++
 tb/tb_count_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_mon_pkg : shared widths and state encoding for count_monitor    |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package count_mon_pkg;

    localparam int COUNT_W   = 8;
    localparam int ERRCNT_W  = 8;
    localparam int WRAPCNT_W = 16;
    localparam int CONSEC_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAIL  = 2'd2
    } state_e;

    // Value the observed counter should show one edge after (cnt, en).
    function automatic logic [COUNT_W-1:0] next_expected(
        input logic [COUNT_W-1:0] cnt,
        input logic               en
    );
        return cnt + COUNT_W'(en);
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_mon_sat_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_mon_sat_ctr : saturating up-counter with synchronous clear      |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module count_mon_sat_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_VAL)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_monitor : checks an 8-bit counter against its enable/reset and  |
// |                 reports lock, mismatches and rollovers.               |
// | Option        : COUNT_MON_WRAP_CNT_EN builds the rollover counter.    |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int ERR_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctrl,
    input  logic                 cnt_reset,
    input  logic [COUNT_W-1:0]   count,
    output logic                 locked,
    output logic                 fail,
    output logic                 err,
    output logic [ERRCNT_W-1:0]  err_count,
    output logic                 wrap,
    output logic [WRAPCNT_W-1:0] wrap_count
);

    localparam logic [CONSEC_W-1:0] THRESH_M1 = CONSEC_W'(ERR_THRESH - 1);

    state_e               state_d,      state_q;
    logic [COUNT_W-1:0]   prev_count_d, prev_count_q;
    logic                 prev_ctrl_d,  prev_ctrl_q;
    logic                 err_d,        err_q;
    logic                 wrap_d,       wrap_q;

    logic [COUNT_W-1:0]   expected;
    logic [CONSEC_W-1:0]  consec;
    logic                 consec_clr;
    logic                 consec_inc;
    logic                 err_inc;

    always_comb begin
        state_d      = state_q;
        prev_count_d = count;
        prev_ctrl_d  = ctrl;
        err_d        = 1'b0;
        wrap_d       = 1'b0;
        consec_clr   = 1'b0;
        consec_inc   = 1'b0;
        err_inc      = 1'b0;
        expected     = next_expected(prev_count_q, prev_ctrl_q);

        if (cnt_reset) begin
            // The counter restarts from zero, so the history is zeroed too.
            state_d      = IDLE;
            prev_count_d = '0;
            prev_ctrl_d  = 1'b0;
            consec_clr   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                end
                TRACK, FAIL: begin
                    if (count == expected) begin
                        consec_clr = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_inc    = 1'b1;
                        consec_inc = 1'b1;
                        if ((state_q == TRACK) && (consec >= THRESH_M1)) begin
                            state_d = FAIL;
                        end
                    end
                    wrap_d = (prev_count_q == {COUNT_W{1'b1}}) && prev_ctrl_q &&
                             (count == '0);
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            prev_count_q <= '0;
            prev_ctrl_q  <= 1'b0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_ctrl_q  <= prev_ctrl_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
        end
    end

    count_mon_sat_ctr #(
        .WIDTH (CONSEC_W)
    ) u_consec_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (consec_clr),
        .inc   (consec_inc),
        .count (consec)
    );

    count_mon_sat_ctr #(
        .WIDTH (ERRCNT_W)
    ) u_err_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (err_inc),
        .count (err_count)
    );

`ifdef COUNT_MON_WRAP_CNT_EN
    logic [WRAPCNT_W-1:0] wrap_count_d;
    logic [WRAPCNT_W-1:0] wrap_count_q;

    // Free-running modulo-2^16 total; it moves on the same edge as wrap.
    always_comb begin
        wrap_count_d = wrap_count_q;
        if (wrap_d) begin
            wrap_count_d = wrap_count_q + WRAPCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrap_count_q <= '0;
        end else begin
            wrap_count_q <= wrap_count_d;
        end
    end

    assign wrap_count = wrap_count_q;
`else
    assign wrap_count = '0;
`endif

    assign locked = (state_q == TRACK);
    assign fail   = (state_q == FAIL);
    assign err    = err_q;
    assign wrap   = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// Testbench for count_monitor: a behavioural model queues the expected
// outputs for every driven sample; each scenario pops and compares them.
module tb_count_monitor;

    localparam int ERR_THRESH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl = 1'b0;
    logic        cnt_reset = 1'b0;
    logic [7:0]  count = 8'd0;
    logic        locked;
    logic        fail;
    logic        err;
    logic [7:0]  err_count;
    logic        wrap;
    logic [15:0] wrap_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: 0 idle, 1 track, 2 fail
    int m_st = 0;
    int m_prev = 0;
    int m_pc = 0;
    int m_consec = 0;
    int m_ec = 0;
    int m_wc = 0;

    logic [27:0] sb[$];
    logic [27:0] got;
    logic [27:0] exp_v;

    count_monitor #(.ERR_THRESH(ERR_THRESH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl       (ctrl),
        .cnt_reset  (cnt_reset),
        .count      (count),
        .locked     (locked),
        .fail       (fail),
        .err        (err),
        .err_count  (err_count),
        .wrap       (wrap),
        .wrap_count (wrap_count)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] obs();
        return {locked, fail, err, wrap, err_count, wrap_count};
    endfunction

    // Expected outputs after one rising edge with the given inputs.
    function automatic logic [27:0] model(input logic r, input logic c,
                                          input logic cr, input logic [7:0] v);
        logic e;
        logic w;
        e = 1'b0;
        w = 1'b0;
        if (!r) begin
            m_st = 0; m_prev = 0; m_pc = 0; m_consec = 0; m_ec = 0; m_wc = 0;
        end else if (cr) begin
            m_st = 0; m_prev = 0; m_pc = 0; m_consec = 0;
        end else begin
            if (m_st == 0) begin
                m_st = 1;
            end else begin
                if (int'(v) != ((m_prev + m_pc) % 256)) begin
                    e = 1'b1;
                    if (m_ec < 255) m_ec++;
                    m_consec++;
                    if (m_st == 1 && m_consec >= ERR_THRESH) m_st = 2;
                end else begin
                    m_consec = 0;
                end
                w = (m_prev == 255) && (m_pc == 1) && (v == 8'd0);
`ifdef COUNT_MON_WRAP_CNT_EN
                if (w) m_wc = (m_wc + 1) % 65536;
`endif
            end
            m_prev = int'(v);
            m_pc   = int'(c);
        end
        return {(m_st == 1), (m_st == 2), e, w, 8'(m_ec), 16'(m_wc)};
    endfunction

    task automatic drive(input logic r, input logic c, input logic cr, input logic [7:0] v);
        reset = r; ctrl = c; cnt_reset = cr; count = v;
        sb.push_back(model(r, c, cr, v));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'd33);
            got = obs(); exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL reset[%0d]: got=%h want=%h", i, got, exp_v);
            end
        end
        n_cmp++;
        if (obs() !== 28'd0) begin
            n_fail++; $display("FAIL reset_zero: got=%h want=0", obs());
        end
    endtask

    task automatic test_count_up();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        void'(sb.pop_front());
        for (int i = 0; i <= 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(i));
            got = obs(); exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL count_up[%0d]: got=%h want=%h", i, got, exp_v);
            end
        end
        n_cmp++;
        if ({locked, err_count} !== {1'b1, 8'd0}) begin
            n_fail++; $display("FAIL count_up_end: locked=%b errc=%0d want 1/0", locked, err_count);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i >= 5), 1'b0, (i <= 5) ? 8'd7 : 8'(i + 2));
            got = obs(); exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL hold[%0d]: got=%h want=%h", i, got, exp_v);
            end
        end
        n_cmp++;
        if ({locked, err_count} !== {1'b1, 8'd0}) begin
            n_fail++; $display("FAIL hold_end: locked=%b errc=%0d want 1/0", locked, err_count);
        end
    endtask

    task automatic test_single_err();
        logic [7:0] seq [8];
        seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10, 8'd11};
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, seq[i]);
            got = obs(); exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL single_err[%0d]: got=%h want=%h", i, got, exp_v);
            end
        end
        n_cmp++;
        if ({locked, fail, err_count} !== {1'b1, 1'b0, 8'd1}) begin
            n_fail++; $display("FAIL single_err_end: lk=%b fl=%b errc=%0d want 1/0/1", locked, fail, err_count);
        end
    endtask

    task automatic test_fail_recover();
        logic [7:0] seq [11];
        logic       crs [11];
        seq = '{8'd0, 8'd1, 8'd2, 8'd50, 8'd60, 8'd70, 8'd80, 8'd81, 8'd5, 8'd0, 8'd1};
        crs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b1, crs[i], seq[i]);
            got = obs(); exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL fail_recover[%0d]: got=%h want=%h", i, got, exp_v);
            end
            if (i == 6) begin
                n_cmp++;
                if ({fail, err, err_count} !== {1'b1, 1'b1, 8'd4}) begin
                    n_fail++; $display("FAIL fail_enter: fl=%b err=%b errc=%0d want 1/1/4", fail, err, err_count);
                end
            end
        end
        n_cmp++;
        if ({locked, fail} !== 2'b10) begin
            n_fail++; $display("FAIL fail_exit: lk=%b fl=%b want 1/0", locked, fail);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        void'(sb.pop_front());
        for (int i = 250; i <= 257; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(i));
            got = obs(); exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL wrap[%0d]: got=%h want=%h", i, got, exp_v);
            end
        end
        n_cmp++;
`ifdef COUNT_MON_WRAP_CNT_EN
        if (wrap_count !== 16'd1) begin
`else
        if (wrap_count !== 16'd0) begin
`endif
            n_fail++; $display("FAIL wrap_total: got=%0d", wrap_count);
        end
    endtask

    task automatic test_saturate();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 301; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd0);
            got = obs(); exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL saturate[%0d]: got=%h want=%h", i, got, exp_v);
            end
        end
        n_cmp++;
        if ({fail, err_count} !== {1'b1, 8'd255}) begin
            n_fail++; $display("FAIL sat_level: fl=%b errc=%0d want 1/255", fail, err_count);
        end
        // reset must win over cnt_reset and a mismatching sample mid-FAIL
        drive(1'b0, 1'b1, 1'b1, 8'd99);
        got = obs(); exp_v = sb.pop_front(); n_cmp++;
        if (got !== exp_v || got !== 28'd0) begin
            n_fail++; $display("FAIL sat_reset: got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic       c;
        logic       cr;
        v = 8'd0;
        c = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 300; i++) begin
            cr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) v = 8'($urandom_range(0, 255));
            drive(1'b1, c, cr, v);
            got = obs(); exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL b2b[%0d]: got=%h want=%h", i, got, exp_v);
            end
            v = cr ? 8'd0 : v + 8'(c);
            c = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_count_up();
        test_hold();
        test_single_err();
        test_fail_recover();
        test_wrap();
        test_saturate();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
